// File: rtl/dm_arb_pkg.sv
// Shared definitions for the data-memory arbiter: parameter defaults and
// the encoding of the port that owns the memory in a given cycle.
package dm_arb_pkg;

  localparam int ADDR_W_DEF       = 8;
  localparam int DATA_W_DEF       = 32;
  localparam int VGA_MAX_WAIT_DEF = 4;

  typedef enum logic [1:0] {
    SEL_NONE = 2'd0,
    SEL_CPU  = 2'd1,
    SEL_VGA  = 2'd2
  } sel_e;

endpackage

// File: rtl/dm_arb_rport.sv
// Read-return register: captures memory read data for one port and
// raises a one-cycle valid pulse on the following cycle.
module dm_arb_rport #(
  parameter int DATA_W = 32
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              CAP,
  input  logic [DATA_W-1:0] DIN,
  output logic [DATA_W-1:0] RD,
  output logic              RVALID
);

  // NOTE: reset is sampled on the clock edge only, and all state updates use
  // non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      RD     <= '0;
      RVALID <= 1'b0;
    end else begin
      RVALID <= CAP;
      if (CAP) RD <= DIN;
    end
  end

endmodule

// File: rtl/dm_arbiter.sv
// Two-port arbiter sharing the data memory between the CPU load/store unit
// and the VGA fetcher, with starvation protection for the VGA side.
module dm_arbiter
  import dm_arb_pkg::*;
#(
  parameter int ADDR_W       = ADDR_W_DEF,
  parameter int DATA_W       = DATA_W_DEF,
  parameter int VGA_MAX_WAIT = VGA_MAX_WAIT_DEF
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              CPU_REQ,
  input  logic              CPU_WE,
  input  logic [ADDR_W-1:0] CPU_ADDR,
  input  logic [DATA_W-1:0] CPU_WD,
  output logic              CPU_GNT,
  output logic              CPU_RVALID,
  output logic [DATA_W-1:0] CPU_RD,
  input  logic              VGA_REQ,
  input  logic [ADDR_W-1:0] VGA_ADDR,
  output logic              VGA_GNT,
  output logic              VGA_RVALID,
  output logic [DATA_W-1:0] VGA_RD,
  output logic              DM_WE,
  output logic [31:0]       DM_A,
  output logic [DATA_W-1:0] DM_WD,
  input  logic [DATA_W-1:0] DM_RD
);

  localparam int CNT_W = $clog2(VGA_MAX_WAIT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(VGA_MAX_WAIT);

  sel_e              sel;
  logic              prio_vga;
  logic [CNT_W-1:0]  wait_cnt;
  logic [CNT_W-1:0]  cnt_inc;
  logic [ADDR_W-1:0] last_a;
  logic [ADDR_W-1:0] dm_a_w;

  // NOTE: every signal assigned in always_comb gets a default first, so no
  // path through the block can leave it unassigned and infer a latch.
  always_comb begin
    sel = SEL_NONE;
    if (RST_N) begin
      if (CPU_REQ && !(VGA_REQ && prio_vga)) sel = SEL_CPU;
      else if (VGA_REQ)                      sel = SEL_VGA;
    end
  end

  assign CPU_GNT = (sel == SEL_CPU);
  assign VGA_GNT = (sel == SEL_VGA);

  always_comb begin
    cnt_inc = (wait_cnt == CNT_MAX) ? wait_cnt : wait_cnt + CNT_W'(1);
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      wait_cnt <= '0;
      prio_vga <= 1'b0;
    end else if (VGA_GNT) begin
      wait_cnt <= '0;
      prio_vga <= 1'b0;
    end else if (VGA_REQ) begin
      wait_cnt <= cnt_inc;
      if (cnt_inc == CNT_MAX) prio_vga <= 1'b1;
    end
  end

  // With no grant the address bus parks on the last driven address.
  always_comb begin
    unique case (sel)
      SEL_CPU: dm_a_w = CPU_ADDR;
      SEL_VGA: dm_a_w = VGA_ADDR;
      default: dm_a_w = last_a;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) last_a <= '0;
    else        last_a <= dm_a_w;
  end

  assign DM_A  = {{(32 - ADDR_W){1'b0}}, dm_a_w};
  assign DM_WE = CPU_GNT & CPU_WE;
  assign DM_WD = CPU_WD;

  dm_arb_rport #(.DATA_W(DATA_W)) u_cpu_rport (
    .CLK    (CLK),
    .RST_N  (RST_N),
    .CAP    (CPU_GNT & ~CPU_WE),
    .DIN    (DM_RD),
    .RD     (CPU_RD),
    .RVALID (CPU_RVALID)
  );

  dm_arb_rport #(.DATA_W(DATA_W)) u_vga_rport (
    .CLK    (CLK),
    .RST_N  (RST_N),
    .CAP    (VGA_GNT),
    .DIN    (DM_RD),
    .RD     (VGA_RD),
    .RVALID (VGA_RVALID)
  );

endmodule
